// File: rtl/lcd_write_fsm.sv
// Byte writer for a 4-bit HD44780-style LCD bus: replays the power-on configuration
// bytes, then sends user bytes as two enable-strobed nibbles followed by an execution wait.
module lcd_write_fsm #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cfg_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] sf_d
);

  // state     | meaning
  // WAIT_INIT | waiting for init_done, bus idle
  // CFG_LOAD  | latch configuration byte k
  // IDLE      | ready for a user byte
  // U_SETUP   | upper nibble on bus, E low
  // U_PULSE   | upper nibble, E high
  // U_HOLD    | upper nibble held, E low
  // GAP       | inter-nibble gap, bus zero
  // L_SETUP   | lower nibble on bus, E low
  // L_PULSE   | lower nibble, E high
  // L_HOLD    | lower nibble held, E low
  // EXEC      | LCD execution wait
  localparam logic [3:0] WAIT_INIT = 4'd0;
  localparam logic [3:0] CFG_LOAD  = 4'd1;
  localparam logic [3:0] IDLE      = 4'd2;
  localparam logic [3:0] U_SETUP   = 4'd3;
  localparam logic [3:0] U_PULSE   = 4'd4;
  localparam logic [3:0] U_HOLD    = 4'd5;
  localparam logic [3:0] GAP       = 4'd6;
  localparam logic [3:0] L_SETUP   = 4'd7;
  localparam logic [3:0] L_PULSE   = 4'd8;
  localparam logic [3:0] L_HOLD    = 4'd9;
  localparam logic [3:0] EXEC      = 4'd10;

  localparam logic [16:0] LD_SETUP = 17'(T_SETUP - 1);
  localparam logic [16:0] LD_PULSE = 17'(T_PULSE - 1);
  localparam logic [16:0] LD_HOLD  = 17'(T_HOLD - 1);
  localparam logic [16:0] LD_GAP   = 17'(T_GAP - 1);
  localparam logic [16:0] LD_EXEC  = 17'(T_EXEC - 1);
  localparam logic [16:0] LD_CLEAR = 17'(T_CLEAR - 1);

  logic [3:0]  state;
  logic [16:0] cnt;
  logic [1:0]  cfg_idx;
  logic [7:0]  xfer_byte;
  logic        xfer_rs;
  logic        is_clear;
  logic        in_upper;
  logic        in_lower;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  assign is_clear = !xfer_rs && (xfer_byte == 8'h01 || xfer_byte == 8'h02);

  // cnt is a down-counter loaded with (duration - 1) on state entry; zero is terminal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_INIT;
      cnt       <= '0;
      cfg_idx   <= '0;
      cfg_done  <= 1'b0;
      xfer_byte <= '0;
      xfer_rs   <= 1'b0;
    end else if (!init_done && state != WAIT_INIT) begin
      state     <= WAIT_INIT;
      cnt       <= '0;
      cfg_idx   <= '0;
      cfg_done  <= 1'b0;
      xfer_byte <= '0;
      xfer_rs   <= 1'b0;
    end else begin
      case (state)
        WAIT_INIT: begin
          cnt <= '0;
          if (init_done) state <= CFG_LOAD;
        end
        CFG_LOAD: begin
          xfer_byte <= cfg_byte(cfg_idx);
          xfer_rs   <= 1'b0;
          cnt       <= LD_SETUP;
          state     <= U_SETUP;
        end
        IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            xfer_byte <= cmd_data;
            xfer_rs   <= cmd_rs;
            cnt       <= LD_SETUP;
            state     <= U_SETUP;
          end
        end
        U_SETUP: if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= U_PULSE; cnt <= LD_PULSE; end
        U_PULSE: if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= U_HOLD; cnt <= LD_HOLD; end
        U_HOLD:  if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= GAP; cnt <= LD_GAP; end
        GAP:     if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= L_SETUP; cnt <= LD_SETUP; end
        L_SETUP: if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= L_PULSE; cnt <= LD_PULSE; end
        L_PULSE: if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= L_HOLD; cnt <= LD_HOLD; end
        L_HOLD:  if (cnt != '0) cnt <= cnt - 17'd1;
                 else begin state <= EXEC; cnt <= is_clear ? LD_CLEAR : LD_EXEC; end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 17'd1;
          end else if (cfg_done) begin
            state <= IDLE;
          end else if (cfg_idx == 2'd3) begin
            cfg_done <= 1'b1;
            state    <= IDLE;
          end else begin
            cfg_idx <= cfg_idx + 2'd1;
            state   <= CFG_LOAD;
          end
        end
        default: begin
          state <= WAIT_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    in_upper  = (state == U_SETUP) || (state == U_PULSE) || (state == U_HOLD);
    in_lower  = (state == L_SETUP) || (state == L_PULSE) || (state == L_HOLD);
    cmd_ready = (state == IDLE);
    lcd_e     = (state == U_PULSE) || (state == L_PULSE);
    lcd_rs    = (in_upper || in_lower || state == GAP) ? xfer_rs : 1'b0;
    lcd_rw    = 1'b0;
    sf_d      = 4'd0;
    if (in_upper)      sf_d = xfer_byte[7:4];
    else if (in_lower) sf_d = xfer_byte[3:0];
  end

endmodule

// File: tb/tb_lcd_write_fsm.sv
// Randomized bench for lcd_write_fsm: a timeline model predicts every output each cycle,
// plus scenario checks on configuration, user bytes, init_done loss and async reset.
module tb_lcd_write_fsm;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 12;
  localparam int T_HOLD  = 1;
  localparam int T_GAP   = 50;
  localparam int T_EXEC  = 200;
  localparam int T_CLEAR = 900;
  localparam int NIB     = T_SETUP + T_PULSE + T_HOLD;
  localparam int BUS     = 2 * NIB + T_GAP;
  localparam int BUDGET  = 5000;

  logic       clk, reset, init_done, cmd_valid, cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready, cfg_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] sf_d;

  lcd_write_fsm #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .T_GAP(T_GAP), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .cmd_valid(cmd_valid),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .cfg_done(cfg_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_d(sf_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic prev_e = 1'b0;
  logic [3:0] pulses[$];
  int pulse_cyc[$];

  typedef enum {M_WAIT, M_LOAD, M_XFER, M_IDLE} mode_t;
  mode_t      m_mode;
  int         m_k, m_off;
  bit         m_done;
  logic [7:0] m_byte;
  logic       m_rs;
  logic [7:0] cfg_bytes [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
  logic [3:0] cfg_nibs  [8] = '{4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int xfer_len(input logic r, input logic [7:0] b);
    return BUS + ((!r && (b == 8'h01 || b == 8'h02)) ? T_CLEAR : T_EXEC);
  endfunction

  // Outputs expected in the current cycle, from the offset into the transfer timeline.
  function automatic logic [8:0] model_outs();
    logic ready, e, rs;
    logic [3:0] nib;
    int o;
    ready = (m_mode == M_IDLE);
    e = 1'b0; rs = 1'b0; nib = 4'd0;
    if (m_mode == M_XFER) begin
      o = m_off;
      if (o < NIB) begin
        nib = m_byte[7:4]; rs = m_rs; e = (o >= T_SETUP) && (o < T_SETUP + T_PULSE);
      end else if (o < NIB + T_GAP) begin
        rs = m_rs;
      end else if (o < BUS) begin
        o = o - NIB - T_GAP;
        nib = m_byte[3:0]; rs = m_rs; e = (o >= T_SETUP) && (o < T_SETUP + T_PULSE);
      end
    end
    return {ready, m_done, e, rs, 1'b0, nib};
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT; m_k = 0; m_off = 0; m_done = 0; m_byte = 8'h00; m_rs = 1'b0;
  endtask

  task automatic model_step();
    if (reset) model_reset();
    else if (!init_done && m_mode != M_WAIT) begin
      m_mode = M_WAIT; m_k = 0; m_done = 0;
    end else begin
      case (m_mode)
        M_WAIT: if (init_done) m_mode = M_LOAD;
        M_LOAD: begin m_byte = cfg_bytes[m_k]; m_rs = 1'b0; m_off = 0; m_mode = M_XFER; end
        M_IDLE: if (cmd_valid) begin m_byte = cmd_data; m_rs = cmd_rs; m_off = 0; m_mode = M_XFER; end
        M_XFER: begin
          m_off++;
          if (m_off == xfer_len(m_rs, m_byte)) begin
            if (m_done) m_mode = M_IDLE;
            else if (m_k == 3) begin m_done = 1; m_mode = M_IDLE; end
            else begin m_k++; m_mode = M_LOAD; end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("outs", {23'd0, cmd_ready, cfg_done, lcd_e, lcd_rs, lcd_rw, sf_d}, {23'd0, model_outs()});
    if (lcd_e && !prev_e) begin
      pulses.push_back(sf_d);
      pulse_cyc.push_back(cyc);
    end
    prev_e = lcd_e;
  endtask

  task automatic run_config();
    int n, p0;
    p0 = pulses.size();
    init_done = 1'b1;
    n = 0;
    while (!cfg_done && n < BUDGET) begin tick(); n++; end
    check("cfg_latency", n, 4 + 3 * (BUS + T_EXEC) + (BUS + T_CLEAR) + 1);
    check("cfg_pulses", pulses.size() - p0, 8);
    for (int i = 0; i < 8; i++)
      if (p0 + i < pulses.size()) check("cfg_nib", pulses[p0 + i], cfg_nibs[i]);
  endtask

  task automatic send_byte(input logic r, input logic [7:0] d, input bit churn);
    int n, acc, p0, low;
    n = 0;
    while (!cmd_ready && n < BUDGET) begin tick(); n++; end
    check("ready_wait", cmd_ready, 1);
    p0 = pulses.size();
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    tick();
    acc = cyc;
    check("accepted", cmd_ready, 0);
    if (!churn) cmd_valid = 1'b0;
    low = 0;
    while (!cmd_ready && low < BUDGET) begin
      low++;
      if (churn) begin cmd_data = 8'($urandom); cmd_rs = 1'($urandom); end
      tick();
    end
    check("ready_low", low, xfer_len(r, d));
    check("pulse_cnt", pulses.size() - p0, 2);
    if (pulses.size() >= p0 + 2) begin
      check("up_nib", pulses[p0], d[7:4]);
      check("lo_nib", pulses[p0 + 1], d[3:0]);
      check("up_start", pulse_cyc[p0] - acc, T_SETUP);
      check("lo_start", pulse_cyc[p0 + 1] - pulse_cyc[p0], NIB + T_GAP);
    end
  endtask

  task automatic start_byte(input logic r, input logic [7:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < BUDGET) begin tick(); n++; end
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_e(input logic level, input string tag);
    int n;
    n = 0;
    while (lcd_e !== level && n < BUDGET) begin tick(); n++; end
    check(tag, lcd_e, level);
  endtask

  initial begin
    int p0;
    logic r;
    logic [7:0] d;
    reset = 1'b1; init_done = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_outs", {cmd_ready, cfg_done, lcd_e, lcd_rs, lcd_rw, sf_d}, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("wait_outs", {cmd_ready, cfg_done, lcd_e, lcd_rs, lcd_rw, sf_d}, 0);

    run_config();

    send_byte(1'b1, 8'h41, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h80, 1'b0);
    send_byte(1'b1, 8'h02, 1'b1);
    send_byte(1'b0, 8'h02, 1'b1);
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom);
      d = 8'($urandom);
      if (i == 5) begin r = 1'b0; d = 8'h01; end
      send_byte(r, d, 1'($urandom));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end

    // Lose init_done while E is high on a user byte.
    start_byte(1'b1, 8'h5A);
    wait_e(1'b1, "drop_find_pulse");
    init_done = 1'b0;
    tick();
    check("drop_e", lcd_e, 0);
    check("drop_sfd", sf_d, 0);
    check("drop_cfg", cfg_done, 0);
    repeat (5) tick();
    run_config();

    // Async reset during the inter-nibble gap.
    start_byte(1'b1, 8'hC3);
    wait_e(1'b1, "rst_find_pulse");
    wait_e(1'b0, "rst_find_hold");
    repeat (3) tick();
    check("in_gap_rs", lcd_rs, 1);
    #2 reset = 1'b1; init_done = 1'b0;
    #1 check("async_rst", {cmd_ready, cfg_done, lcd_e, lcd_rs, lcd_rw, sf_d}, 0);
    repeat (3) tick();
    reset = 1'b0;
    p0 = pulses.size();
    repeat (30) tick();
    check("no_pulse_wo_init", pulses.size() - p0, 0);
    run_config();
    send_byte(1'b1, 8'h7E, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
